fft_reorder_pingpong: RTL and testbench

Parametrised output reorder buffer for the R2 pipeline FFT. It takes natural-order FFT results and returns them in bin order, with bit-reversed or natural addressing selectable per frame. It uses two ping-pong banks, so the FFT can write frame k+1 while frame k drains. The output uses a valid/ready handshake with an optional per-sample hold for slow consumers such as display or UART.

---
 rtl/fft_reorder_pingpong_if.sv | 33 +++
 rtl/fft_reorder_pingpong.sv | 214 +++++++++++++++++++++
 tb/tb_fft_reorder_pingpong.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_reorder_pingpong_if.sv
// Handshake bundle for the FFT output reorder buffer: write stream in,
// reordered bin stream out, plus overflow and bank status.
interface fft_reorder_pingpong_if #(
    parameter int WIDTH = 16,
    parameter int N     = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    bitrev_en;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [N-1:0]            out_idx;
    logic                    out_last;
    logic                    overflow;
    logic                    clr_ovf;
    logic [1:0]              bank_full;

    // Producer/consumer side (FFT core and sink)
    modport master (
        output in_valid, in_re, in_im, bitrev_en, out_ready, clr_ovf,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last, overflow, bank_full
    );

    // Reorder buffer side
    modport slave (
        input  in_valid, in_re, in_im, bitrev_en, out_ready, clr_ovf,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last, overflow, bank_full
    );
endinterface

// File: rtl/fft_reorder_pingpong.sv
// Ping-pong output reorder buffer for the R2 pipeline FFT. Natural-order
// samples fill one bank while the other drains in bit-reversed or natural
// bin order through a 2-entry skid stage, with optional per-sample hold.
module fft_reorder_pingpong #(
    parameter int WIDTH  = 16,
    parameter int N      = 9,
    parameter int HOLD   = 0,
    parameter int HOLD_W = 24
) (
    input  logic                  clk,
    input  logic                  areset,
    fft_reorder_pingpong_if.slave bus
);
    localparam int           DEPTH    = 1 << N;
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic [N-1:0]     idx;
    } entry_t;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = a[N-1-i];
        return r;
    endfunction

    // Both banks live in one array; the bank select is the address MSB.
    logic [2*WIDTH-1:0] mem [2*DEPTH];
    logic [2*WIDTH-1:0] ram_q;

    logic [1:0]        bank_full;
    logic              wr_bank;
    logic              rd_bank;
    logic [N-1:0]      wr_cnt;
    logic              overflow;
    logic [1:0]        state;
    logic              mode;
    logic [N-1:0]      issue_cnt;
    logic              issue_done;
    logic              pending;
    logic [N-1:0]      pending_idx;
    logic [1:0]        count;
    entry_t            e0;
    entry_t            e1;
    logic [HOLD_W-1:0] hold_cnt;

    logic         in_ready;
    logic         wr_fire;
    logic         drop;
    logic         wr_done;
    logic         out_valid;
    logic         pop;
    logic         last_pop;
    logic         start;
    logic         issue_run;
    logic         issue;
    logic [1:0]   occ;
    logic [N-1:0] rd_addr;
    entry_t       q_entry;
    entry_t       head;
    entry_t       slot0;
    entry_t       slot1;

    assign in_ready = !bank_full[wr_bank];
    assign wr_fire  = bus.in_valid && in_ready;
    assign drop     = bus.in_valid && !in_ready;
    assign wr_done  = wr_fire && (wr_cnt == LAST_IDX);

    // The sample whose RAM read was issued last cycle, tagged with its bin.
    assign q_entry = '{re: ram_q[2*WIDTH-1:WIDTH], im: ram_q[WIDTH-1:0], idx: pending_idx};

    // Logical output queue = registered entries followed by the RAM word in flight.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head  = e0;
        slot0 = e0;
        slot1 = e1;
        if (count == 2'd0) begin
            slot0 = q_entry;
            if (pending) head = q_entry;
        end
        if (count == 2'd1) slot1 = q_entry;
    end

    assign out_valid = (state == ST_RUN) && ((count != 2'd0) || pending);
    assign pop       = out_valid && bus.out_ready;
    assign last_pop  = pop && (head.idx == LAST_IDX);
    assign start     = (state == ST_IDLE) && bank_full[rd_bank];

    // Occupancy after this cycle's pop; a new read may issue while it is below 2.
    assign occ       = count + {1'b0, pending} - {1'b0, pop};
    assign issue_run = (state != ST_IDLE) && !issue_done && (occ < 2'd2);
    assign issue     = start || issue_run;
    // Bin 0 is address 0 in either mode, so the first read issues straight from IDLE.
    assign rd_addr   = start ? '0 : (mode ? bitrev(issue_cnt) : issue_cnt);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_re    = head.re;
    assign bus.out_im    = head.im;
    assign bus.out_idx   = head.idx;
    assign bus.out_last  = out_valid && (head.idx == LAST_IDX);
    assign bus.overflow  = overflow;
    assign bus.bank_full = bank_full;

    // Sample RAM: one write port for the filling bank, one registered read port.
    // NOTE: storage has no reset; contents are don't-care until written, and the skid/pending flags gate what is seen.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank, wr_cnt}] <= {bus.in_re, bus.in_im};
        if (issue)   ram_q <= mem[{rd_bank, rd_addr}];
    end

    // Write address, bank toggle and sticky overflow (a drop beats a clear).
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + N'(1);
                if (wr_done) wr_bank <= ~wr_bank;
            end
            if (drop) overflow <= 1'b1;
            else if (bus.clr_ovf) overflow <= 1'b0;
        end
    end

    // Bank flags: filled by the writer, released by the last output handshake.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full | (wr_done ? (2'b01 << wr_bank) : 2'b00))
                       & ~(last_pop ? (2'b01 << rd_bank) : 2'b00);
        end
    end

    // Read FSM: frame start latches the addressing mode, HOLD spaces samples out.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state    <= ST_IDLE;
            mode     <= 1'b0;
            rd_bank  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        mode  <= bus.bitrev_en;
                    end
                end
                ST_RUN: begin
                    if (last_pop) begin
                        state   <= ST_IDLE;
                        rd_bank <= ~rd_bank;
                    end else if (pop && (HOLD > 0)) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD - 1)) state <= ST_RUN;
                    else hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read issue counter: walks bins 0..2^N-1 once per frame, ahead of the consumer.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            issue_cnt   <= '0;
            issue_done  <= 1'b0;
            pending     <= 1'b0;
            pending_idx <= '0;
        end else begin
            pending <= issue;
            if (start) begin
                issue_cnt   <= N'(1);
                issue_done  <= 1'b0;
                pending_idx <= '0;
            end else if (issue_run) begin
                pending_idx <= issue_cnt;
                issue_cnt   <= issue_cnt + N'(1);
                if (issue_cnt == LAST_IDX) issue_done <= 1'b1;
            end
        end
    end

    // Skid stage: absorbs the RAM word in flight whenever the consumer stalls.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            count <= occ;
            if (pending || pop) begin
                e0 <= pop ? slot1 : slot0;
                e1 <= pop ? q_entry : slot1;
            end
        end
    end
endmodule

// File: tb/tb_fft_reorder_pingpong.sv
// Self-checking bench for fft_reorder_pingpong: a full-rate instance (HOLD=0)
// checked every cycle against a frame-level scoreboard, and a HOLD=3 instance
// checked for output pacing.
module tb_fft_reorder_pingpong;
    localparam int W     = 16;
    localparam int NB    = 3;
    localparam int FRAME = 1 << NB;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        int           idx;
    } exp_t;

    logic clk    = 1'b0;
    logic areset = 1'b0;
    always #5 clk = ~clk;

    fft_reorder_pingpong_if #(.WIDTH(W), .N(NB)) if0 ();
    fft_reorder_pingpong_if #(.WIDTH(W), .N(NB)) if1 ();

    fft_reorder_pingpong #(.WIDTH(W), .N(NB), .HOLD(0), .HOLD_W(24)) dut0 (
        .clk(clk), .areset(areset), .bus(if0)
    );
    fft_reorder_pingpong #(.WIDTH(W), .N(NB), .HOLD(3), .HOLD_W(4)) dut1 (
        .clk(clk), .areset(areset), .bus(if1)
    );

    int          n_checks    = 0;
    int          n_err       = 0;
    int          cyc         = 0;
    int          acc_cnt     = 0;
    int          last_wr_cyc = 0;
    int          m_nfull     = 0;
    logic        m_ovf       = 1'b0;
    exp_t        exp_q[$];
    logic [31:0] part[$];
    logic        stalled     = 1'b0;
    logic [63:0] stall_val   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Bin index with its NB address bits mirrored.
    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < NB; i++)
            if (((k >> i) % 2) == 1) r += 1 << (NB - 1 - i);
        return r;
    endfunction

    function automatic logic [63:0] out_view();
        return {28'd0, $unsigned(if0.out_re), $unsigned(if0.out_im), if0.out_idx, if0.out_last};
    endfunction

    // One cycle of dut0: compare against the model, then advance the model by
    // the handshakes that the coming clock edge will perform.
    task automatic tick();
        logic done;
        logic freed;
        logic dropped;
        exp_t e;
        done    = 1'b0;
        freed   = 1'b0;
        dropped = 1'b0;
        #1;
        check("in_ready", if0.in_ready, (m_nfull < 2));
        check("overflow", if0.overflow, m_ovf);
        if (!if0.out_valid) check("out_last_idle", if0.out_last, 0);
        if (stalled) begin
            check("stall_valid", if0.out_valid, 1);
            check("stall_data", out_view(), stall_val);
        end
        stalled = 1'b0;
        if (if0.out_valid) begin
            if (if0.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_re", $unsigned(if0.out_re), e.re);
                    check("out_im", $unsigned(if0.out_im), e.im);
                    check("out_idx", if0.out_idx, e.idx);
                    check("out_last", if0.out_last, (e.idx == FRAME - 1));
                    if (e.idx == FRAME - 1) freed = 1'b1;
                end
            end else begin
                stalled   = 1'b1;
                stall_val = out_view();
            end
        end
        if (if0.in_valid && if0.in_ready) acc_cnt++;
        if (if0.in_valid) begin
            if (m_nfull < 2) begin
                part.push_back({$unsigned(if0.in_re), $unsigned(if0.in_im)});
                if (part.size() == FRAME) begin
                    for (int k = 0; k < FRAME; k++) begin
                        logic [31:0] w;
                        w     = part[if0.bitrev_en ? rev(k) : k];
                        e.re  = w[31:16];
                        e.im  = w[15:0];
                        e.idx = k;
                        exp_q.push_back(e);
                    end
                    part.delete();
                    done        = 1'b1;
                    last_wr_cyc = cyc;
                end
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (if0.clr_ovf) m_ovf = 1'b0;
        m_nfull = m_nfull + int'(done) - int'(freed);
        @(negedge clk);
        cyc++;
    endtask

    task automatic write_frame(input int base, input int im_off);
        for (int k = 0; k < FRAME; k++) begin
            if0.in_valid = 1'b1;
            if0.in_re    = W'(base + k);
            if0.in_im    = W'(im_off + base + k);
            tick();
        end
        if0.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int n = 0; n < budget && !if0.out_valid; n++) tick();
    endtask

    task automatic drain(input string tag, input int budget);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) tick();
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int found;
        if0.in_valid = 1'b0; if0.in_re = '0; if0.in_im = '0; if0.bitrev_en = 1'b1;
        if0.out_ready = 1'b1; if0.clr_ovf = 1'b0;
        if1.in_valid = 1'b0; if1.in_re = '0; if1.in_im = '0; if1.bitrev_en = 1'b1;
        if1.out_ready = 1'b1; if1.clr_ovf = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_out_re", $unsigned(if0.out_re), 0);
        check("rst_out_im", $unsigned(if0.out_im), 0);
        check("rst_out_idx", if0.out_idx, 0);
        check("rst_out_last", if0.out_last, 0);
        check("rst_overflow", if0.overflow, 0);
        check("rst_bank_full", if0.bank_full, 0);
        check("rst_in_ready", if0.in_ready, 1);
        check("rst_hold_out_valid", if1.out_valid, 0);
        areset = 1'b1;
        @(negedge clk);

        // Bit-reversed frame at full rate, with the 2-cycle start latency
        if0.bitrev_en = 1'b1;
        if0.out_ready = 1'b1;
        write_frame(0, 100);
        wait_valid(20);
        check("t1_latency", cyc - last_wr_cyc, 2);
        drain("t1_drain", 40);

        // Natural order; bitrev_en toggling mid-read must not matter
        if0.bitrev_en = 1'b0;
        write_frame(0, 100);
        wait_valid(20);
        check("t2_latency", cyc - last_wr_cyc, 2);
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
            if0.bitrev_en = ~if0.bitrev_en;
            tick();
        end
        check("t2_drain", exp_q.size(), 0);

        // Three back-to-back frames into a stalled reader
        if0.bitrev_en = 1'b1;
        if0.out_ready = 1'b0;
        base = acc_cnt;
        for (int k = 0; k < 3 * FRAME; k++) begin
            if0.in_valid = 1'b1;
            if0.in_re    = W'(k);
            if0.in_im    = W'(100 + k);
            tick();
        end
        if0.in_valid = 1'b0;
        tick();
        check("t3_accepted", acc_cnt - base, 16);
        check("t3_overflow", if0.overflow, 1);
        check("t3_bank_full", if0.bank_full, 2'b11);
        check("t3_in_ready", if0.in_ready, 0);
        if0.out_ready = 1'b1;
        drain("t3_drain", 60);
        if0.clr_ovf = 1'b1;
        tick();
        if0.clr_ovf = 1'b0;
        check("t3_clr_ovf", if0.overflow, 0);

        // HOLD=3 instance: one sample every 4 cycles, bit-reversed order
        for (int k = 0; k < FRAME; k++) begin
            if1.in_valid = 1'b1;
            if1.in_re    = W'(k);
            if1.in_im    = W'(100 + k);
            @(negedge clk);
        end
        if1.in_valid = 1'b0;
        for (int n = 0; n < 20 && !if1.out_valid; n++) @(negedge clk);
        for (int i = 0; i < 4 * FRAME; i++) begin
            check("t4_hold_valid", if1.out_valid, (i % 4 == 0));
            if (if1.out_valid) begin
                check("t4_hold_re", $unsigned(if1.out_re), rev(i / 4));
                check("t4_hold_im", $unsigned(if1.out_im), 100 + rev(i / 4));
                check("t4_hold_idx", if1.out_idx, i / 4);
                check("t4_hold_last", if1.out_last, (i / 4 == FRAME - 1));
            end
            @(negedge clk);
        end

        // Random valid gaps and consumer stalls over 20 frames
        if0.bitrev_en = 1'b1;
        base = acc_cnt;
        for (int n = 0; n < 20000 && ((acc_cnt - base) < 20 * FRAME || exp_q.size() > 0); n++) begin
            if0.in_valid  = ((acc_cnt - base) < 20 * FRAME) && ($urandom_range(0, 9) < 6);
            if0.in_re     = W'($urandom);
            if0.in_im     = W'($urandom);
            if0.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        if0.in_valid = 1'b0;
        check("t5_accepted", acc_cnt - base, 20 * FRAME);
        check("t5_drain", exp_q.size(), 0);

        // Reset during the 4th output sample while the other bank fills
        if0.out_ready = 1'b1;
        if0.clr_ovf   = 1'b1;
        tick();
        if0.clr_ovf = 1'b0;
        write_frame(0, 100);
        found = 0;
        for (int n = 0; n < 30; n++) begin
            if (if0.out_valid && if0.out_idx == 3'd3) begin
                found = 1;
                break;
            end
            if0.in_valid = 1'b1;
            if0.in_re    = W'(50 + n);
            if0.in_im    = W'(150 + n);
            tick();
        end
        check("t6_reached_4th", found, 1);
        if0.in_valid = 1'b0;
        areset = 1'b0;
        #1;
        check("t6_out_valid", if0.out_valid, 0);
        check("t6_out_re", $unsigned(if0.out_re), 0);
        check("t6_out_im", $unsigned(if0.out_im), 0);
        check("t6_out_idx", if0.out_idx, 0);
        check("t6_out_last", if0.out_last, 0);
        check("t6_bank_full", if0.bank_full, 0);
        exp_q.delete();
        part.delete();
        m_nfull = 0;
        m_ovf   = 1'b0;
        stalled = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b1;
        #1;
        check("t6_in_ready", if0.in_ready, 1);
        @(negedge clk);
        write_frame(200, 100);
        wait_valid(20);
        check("t6_first_idx", if0.out_idx, 0);
        drain("t6_drain", 40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
